// File: rtl/vector_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module : vector_pe_sequencer
// Brief  : Walks a vector command word by word through an external PE,
//          reading operands from and writing results back to a register file.
// Rev    : 1.0  initial release
// ============================================================================
module vector_pe_sequencer #(
  parameter int IDX_W = 5,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [7:0]       i_cmd_instr,
  input  logic [31:0]      i_cmd_sew,
  input  logic [3:0]       i_cmd_vap,
  input  logic [IDX_W:0]   i_cmd_vl,

  output logic [IDX_W-1:0] o_rf_raddr,
  input  logic [31:0]      i_rf_rdata_a,
  input  logic [31:0]      i_rf_rdata_b,
  input  logic [31:0]      i_rf_rdata_c,

  output logic [7:0]       o_pe_instr,
  output logic [31:0]      o_pe_sew,
  output logic [3:0]       o_pe_vap,
  output logic [31:0]      o_pe_opa,
  output logic [31:0]      o_pe_opb,
  output logic [31:0]      o_pe_opc,
  output logic             o_pe_start,
  output logic             o_pe_clr,
  input  logic             i_pe_done,
  input  logic [31:0]      i_pe_out,

  output logic             o_rf_wen,
  output logic [IDX_W-1:0] o_rf_waddr,
  output logic [31:0]      o_rf_wdata,

  output logic             o_busy,
  output logic             o_cmd_done,
  output logic             o_err
);

  localparam int               TMO_W      = $clog2(TMO + 1);
  localparam logic [IDX_W:0]   c_VL_MAX   = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   c_IDX_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] c_TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDX_W:0]   r_idx;
  logic [IDX_W:0]   r_vl;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_instr;
  logic [31:0]      r_sew;
  logic [3:0]       r_vap;
  logic [31:0]      r_opa;
  logic [31:0]      r_opb;
  logic [31:0]      r_opc;
  logic [31:0]      r_res;
  logic             r_cmd_done;
  logic             r_err;
  logic             r_tmo_clr;

  logic             w_sew_ok;
  logic             w_accept;
  logic             w_reject;
  logic             w_timeout;
  logic [IDX_W:0]   w_vl_clamp;
  logic [IDX_W:0]   w_idx_inc;

  assign w_sew_ok   = (i_cmd_sew == 32'd8) || (i_cmd_sew == 32'd16) || (i_cmd_sew == 32'd32);
  assign w_accept   = (r_state == S_IDLE) && i_cmd_valid && w_sew_ok;
  assign w_reject   = (r_state == S_IDLE) && i_cmd_valid && !w_sew_ok;
  assign w_vl_clamp = (i_cmd_vl > c_VL_MAX) ? c_VL_MAX : i_cmd_vl;
  assign w_idx_inc  = r_idx + c_IDX_ONE;
  // A done arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout  = (r_state == S_WAIT) && !i_pe_done && (r_tmo == c_TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_rf_raddr  = '0;
    o_pe_start  = 1'b0;
    o_pe_opa    = r_opa;
    o_pe_opb    = r_opb;
    o_pe_opc    = r_opc;
    o_rf_wen    = 1'b0;
    o_rf_waddr  = '0;
    o_rf_wdata  = '0;
    o_pe_clr    = r_tmo_clr;

    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (w_accept) begin
          w_state_nxt = (w_vl_clamp == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        o_rf_raddr  = r_idx[IDX_W-1:0];
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // Operands flow straight through so they are valid alongside the start pulse.
        o_pe_start  = 1'b1;
        o_pe_opa    = i_rf_rdata_a;
        o_pe_opb    = i_rf_rdata_b;
        o_pe_opc    = i_rf_rdata_c;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_pe_done) begin
          w_state_nxt = S_WRITE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        o_rf_wen    = 1'b1;
        o_rf_waddr  = r_idx[IDX_W-1:0];
        o_rf_wdata  = r_res;
        o_pe_clr    = 1'b1;
        w_state_nxt = (w_idx_inc == r_vl) ? S_FIN : S_READ;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_vl       <= '0;
      r_tmo      <= '0;
      r_instr    <= '0;
      r_sew      <= '0;
      r_vap      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_opc      <= '0;
      r_res      <= '0;
      r_cmd_done <= 1'b0;
      r_err      <= 1'b0;
      r_tmo_clr  <= 1'b0;
    end else begin
      r_cmd_done <= (r_state == S_FIN);
      r_err      <= w_reject || w_timeout;
      r_tmo_clr  <= w_timeout;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_instr <= i_cmd_instr;
            r_sew   <= i_cmd_sew;
            r_vap   <= i_cmd_vap;
            r_vl    <= w_vl_clamp;
            r_idx   <= '0;
          end
        end
        S_ISSUE: begin
          r_opa <= i_rf_rdata_a;
          r_opb <= i_rf_rdata_b;
          r_opc <= i_rf_rdata_c;
          r_tmo <= '0;
        end
        S_WAIT: begin
          if (i_pe_done) begin
            r_res <= i_pe_out;
          end else if (!w_timeout) begin
            r_tmo <= r_tmo + c_TMO_ONE;
          end
        end
        S_WRITE: begin
          r_idx <= w_idx_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_pe_instr = r_instr;
  assign o_pe_sew   = r_sew;
  assign o_pe_vap   = r_vap;
  assign o_cmd_done = r_cmd_done;
  assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vector_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_vector_pe_sequencer
// Brief  : Self-checking bench with RF and PE models for vector_pe_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vector_pe_sequencer;

  localparam int IDX_W = 5;
  localparam int TMO   = 255;
  localparam int NW    = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_instr = '0;
  logic [31:0]      cmd_sew = '0;
  logic [3:0]       cmd_vap = '0;
  logic [IDX_W:0]   cmd_vl = '0;
  logic [IDX_W-1:0] rf_raddr;
  logic [31:0]      rf_rdata_a, rf_rdata_b, rf_rdata_c;
  logic [7:0]       pe_instr;
  logic [31:0]      pe_sew;
  logic [3:0]       pe_vap;
  logic [31:0]      pe_opa, pe_opb, pe_opc;
  logic             pe_start, pe_clr, pe_done;
  logic [31:0]      pe_out;
  logic             rf_wen;
  logic [IDX_W-1:0] rf_waddr;
  logic [31:0]      rf_wdata;
  logic             busy, cmd_done, err;

  always #5 clk = ~clk;

  vector_pe_sequencer #(.IDX_W(IDX_W), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_instr(cmd_instr),
    .i_cmd_sew(cmd_sew), .i_cmd_vap(cmd_vap), .i_cmd_vl(cmd_vl),
    .o_rf_raddr(rf_raddr), .i_rf_rdata_a(rf_rdata_a), .i_rf_rdata_b(rf_rdata_b),
    .i_rf_rdata_c(rf_rdata_c),
    .o_pe_instr(pe_instr), .o_pe_sew(pe_sew), .o_pe_vap(pe_vap),
    .o_pe_opa(pe_opa), .o_pe_opb(pe_opb), .o_pe_opc(pe_opc),
    .o_pe_start(pe_start), .o_pe_clr(pe_clr), .i_pe_done(pe_done), .i_pe_out(pe_out),
    .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_busy(busy), .o_cmd_done(cmd_done), .o_err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane-wise PE semantics: 00 add, 01 subtract, others (a & b) | c.
  function automatic logic [31:0] lane_op(input logic [7:0] op, input logic [31:0] sew,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    logic [31:0] r;
    logic [63:0] m;
    int          w;
    r = '0;
    if (sew != 32'd8 && sew != 32'd16 && sew != 32'd32) return 32'hDEAD_BEEF;
    w = int'(sew);
    m = (64'd1 << w) - 64'd1;
    for (int j = 0; j < 32 / w; j++) begin
      logic [63:0] x, y, z, v;
      x = (64'(a) >> (j * w)) & m;
      y = (64'(b) >> (j * w)) & m;
      z = (64'(c) >> (j * w)) & m;
      case (op)
        8'h00:   v = x + y;
        8'h01:   v = x - y;
        default: v = (x & y) | z;
      endcase
      r = r | 32'((v & m) << (j * w));
    end
    return r;
  endfunction

  logic [31:0] rfa [NW];
  logic [31:0] rfb [NW];
  logic [31:0] rfc [NW];
  always @(posedge clk) begin
    rf_rdata_a <= rfa[rf_raddr];
    rf_rdata_b <= rfb[rf_raddr];
    rf_rdata_c <= rfc[rf_raddr];
  end

  // PE model: done after pe_lat cycles (0 = never), sticky until pe_clr.
  int          pe_lat = 1;
  int          pe_cnt;
  logic [31:0] pe_res;
  always @(posedge clk) begin
    if (reset) begin
      pe_done <= 1'b0;
      pe_out  <= '0;
      pe_res  <= '0;
      pe_cnt  <= 0;
    end else if (pe_start) begin
      pe_res  <= lane_op(pe_instr, pe_sew, pe_opa, pe_opb, pe_opc);
      pe_out  <= lane_op(pe_instr, pe_sew, pe_opa, pe_opb, pe_opc);
      pe_done <= (pe_lat == 1);
      pe_cnt  <= (pe_lat > 1) ? pe_lat - 1 : 0;
    end else begin
      if (pe_clr) pe_done <= 1'b0;
      if (pe_cnt == 1) begin
        pe_done <= 1'b1;
        pe_out  <= pe_res;
      end
      if (pe_cnt > 0) pe_cnt <= pe_cnt - 1;
    end
  end

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t wq[$];
  int n_start = 0, n_clr = 0, n_err = 0, n_done = 0;
  int start_cyc = 0, err_cyc = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (rf_wen) wq.push_back('{int'(rf_waddr), rf_wdata});
    if (pe_start) begin n_start++; start_cyc = cyc; end
    if (pe_clr) n_clr++;
    if (err) begin n_err++; err_cyc = cyc; end
    if (cmd_done) begin n_done++; done_cyc = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] ins, input logic [31:0] sew, input logic [3:0] vap,
                          input logic [IDX_W:0] vl, output int acc);
    wq.delete();
    tick();
    cmd_valid = 1'b1;
    cmd_instr = ins;
    cmd_sew   = sew;
    cmd_vap   = vap;
    cmd_vl    = vl;
    acc       = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_evt(input int budget, input int d0, input int e0, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (n_done != d0 || n_err != e0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_vec(input string tag, input logic [7:0] ins, input logic [31:0] sew,
                         input logic [3:0] vap, input logic [IDX_W:0] vl, input int lat,
                         input int exp_delta, input bit fill, input bit poke);
    int acc, d0, e0, s0, c0, vle, nchk;
    bit seen;
    pe_lat = lat;
    d0 = n_done; e0 = n_err; s0 = n_start; c0 = n_clr;
    if (fill) begin
      for (int i = 0; i < NW; i++) begin
        rfa[i] = $urandom; rfb[i] = $urandom; rfc[i] = $urandom;
      end
    end
    send_cmd(ins, sew, vap, vl, acc);
    if (poke) begin
      cmd_valid = 1'b1; cmd_instr = 8'h5A; cmd_sew = 32'd32; cmd_vap = ~vap;
      tick();
      chk({tag, " ready while busy"}, cmd_ready, 1'b0);
      repeat (5) tick();
      cmd_valid = 1'b0;
    end
    wait_evt(2000, d0, e0, seen);
    tick();
    vle = (int'(vl) > NW) ? NW : int'(vl);
    chk({tag, " completed"}, seen, 1'b1);
    chk({tag, " done latency"}, done_cyc - acc, exp_delta);
    chk({tag, " write count"}, wq.size(), vle);
    chk({tag, " start count"}, n_start - s0, vle);
    chk({tag, " clr count"}, n_clr - c0, vle);
    chk({tag, " no err"}, n_err - e0, 0);
    chk({tag, " held instr/sew/vap"}, {pe_instr, pe_sew, pe_vap}, {ins, sew, vap});
    nchk = (wq.size() < vle) ? wq.size() : vle;
    for (int i = 0; i < nchk; i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), wq[i].addr, i);
      chk($sformatf("%s wr%0d data", tag, i), wq[i].data,
          lane_op(ins, sew, rfa[i], rfb[i], rfc[i]));
    end
  endtask

  typedef struct {
    logic [7:0]     ins;
    logic [31:0]    sew;
    logic [IDX_W:0] vl;
    int             lat;
    int             exp_delta;
    bit             poke;
  } vec_t;
  vec_t vt[7];

  initial begin
    int acc, d0, e0, s0, c0, w0;
    bit seen;

    for (int i = 0; i < NW; i++) begin
      rfa[i] = '0; rfb[i] = '0; rfc[i] = '0;
    end
    repeat (3) tick();
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset pulses", {pe_start, pe_clr, rf_wen, cmd_done, err}, 5'b0);
    chk("reset rf ports", {rf_raddr, rf_waddr, rf_wdata}, '0);
    chk("reset pe fields", {pe_instr, pe_sew, pe_vap}, '0);
    chk("reset pe operands", {pe_opa, pe_opb}, '0);
    chk("reset pe_opc", pe_opc, '0);
    reset = 1'b0;
    tick();

    // Latency: vl*(3+lat)+2 with vl clamped to NW
    vt[0] = '{8'h00, 32'd32, 6'd3,  1, 14,  1'b0};
    vt[1] = '{8'h01, 32'd16, 6'd5,  2, 27,  1'b1};
    vt[2] = '{8'h02, 32'd8,  6'd2,  4, 16,  1'b0};
    vt[3] = '{8'h00, 32'd32, 6'd0,  1, 2,   1'b0};
    vt[4] = '{8'h01, 32'd8,  6'd32, 1, 130, 1'b0};
    vt[5] = '{8'h00, 32'd16, 6'd63, 3, 194, 1'b0};
    vt[6] = '{8'h02, 32'd32, 6'd33, 1, 130, 1'b1};
    for (int v = 0; v < 7; v++) begin
      run_vec($sformatf("vec%0d", v), vt[v].ins, vt[v].sew, 4'(v + 1), vt[v].vl,
              vt[v].lat, vt[v].exp_delta, 1'b1, vt[v].poke);
    end

    rfa[0] = 32'h01FF7F80; rfb[0] = 32'h01010101; rfc[0] = 32'h0;
    run_vec("sew8", 8'h00, 32'd8, 4'h3, 6'd1, 1, 6, 1'b0, 1'b0);
    chk("sew8 lane data", (wq.size() > 0) ? wq[0].data : 32'h0, 32'h02008081);

    // Unsupported element width
    d0 = n_done; e0 = n_err; s0 = n_start;
    send_cmd(8'h00, 32'd12, 4'h0, 6'd4, acc);
    repeat (4) tick();
    chk("badsew err pulses", n_err - e0, 1);
    chk("badsew ready", cmd_ready, 1'b1);
    chk("badsew busy", busy, 1'b0);
    chk("badsew no start", n_start - s0, 0);
    chk("badsew no write/done", {32'(wq.size()), 32'(n_done - d0)}, 64'd0);

    // PE never completes
    pe_lat = 0;
    d0 = n_done; e0 = n_err; s0 = n_start; c0 = n_clr;
    send_cmd(8'h00, 32'd32, 4'h1, 6'd2, acc);
    wait_evt(600, d0, e0, seen);
    tick();
    chk("tmo err seen", seen, 1'b1);
    chk("tmo err delay", err_cyc - start_cyc, 256);
    chk("tmo one start", n_start - s0, 1);
    chk("tmo one clr", n_clr - c0, 1);
    chk("tmo no write", wq.size(), 0);
    chk("tmo no done", n_done - d0, 0);
    chk("tmo idle", {busy, cmd_ready}, 2'b01);

    // Reset while waiting on word 1
    pe_lat = 3;
    d0 = n_done; s0 = n_start;
    for (int i = 0; i < NW; i++) begin
      rfa[i] = $urandom; rfb[i] = $urandom; rfc[i] = $urandom;
    end
    send_cmd(8'h00, 32'd32, 4'h2, 6'd4, acc);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (n_start == s0 + 2) begin seen = 1'b1; break; end
      tick();
    end
    chk("rst reached word1", seen, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("rst busy low", busy, 1'b0);
    chk("rst ready", cmd_ready, 1'b1);
    reset = 1'b0;
    s0 = n_start; w0 = wq.size();
    repeat (20) tick();
    chk("rst no new start", n_start - s0, 0);
    chk("rst writes", {32'(w0), 32'(wq.size())}, {32'd1, 32'd1});
    chk("rst no done", n_done - d0, 0);
    run_vec("after_rst", 8'h01, 32'd32, 4'h6, 6'd2, 1, 10, 1'b1, 1'b0);

    // Randomized commands against the rule-based reference
    for (int r = 0; r < 20; r++) begin
      logic [7:0]     ins;
      logic [31:0]    sew;
      logic [IDX_W:0] vl;
      int             lat, vle;
      ins = 8'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0:       sew = 32'd8;
        1:       sew = 32'd16;
        default: sew = 32'd32;
      endcase
      vl  = (IDX_W + 1)'($urandom_range(0, 40));
      lat = $urandom_range(1, 4);
      vle = (int'(vl) > NW) ? NW : int'(vl);
      run_vec($sformatf("rnd%0d", r), ins, sew, 4'($urandom), vl, lat,
              (vle == 0) ? 2 : vle * (3 + lat) + 2, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
